// File: rtl/fir_mac_sequencer.sv
// Control sequencer for the time-multiplexed halfband FIR datapath: tap bursts,
// pipeline-aligned accumulator strobes, overrun and strobe-phase lock monitoring.
module fir_mac_sequencer #(
  parameter int unsigned NUM_TAPS          = 4,
  parameter int unsigned CW                = 2,
  parameter int unsigned PIPE_DELAY        = 7,
  parameter int unsigned CYCLES_PER_SAMPLE = 4,
  parameter int unsigned LOCK_COUNT        = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          sample_en,
  input  logic          err_clr,
  output logic [CW-1:0] tap_sel,
  output logic          mac_valid,
  output logic          center_en,
  output logic          acc_load,
  output logic          acc_dump,
  output logic          busy,
  output logic          overrun,
  output logic          locked
);

  localparam int unsigned DW   = $clog2(PIPE_DELAY + 1);
  localparam int unsigned DPW  = PIPE_DELAY + 1;
  localparam int unsigned PSAT = 2 * CYCLES_PER_SAMPLE;
  localparam int unsigned PW   = $clog2(PSAT + 1);
  localparam int unsigned LW   = $clog2(LOCK_COUNT + 1);
  localparam logic [CW-1:0] LAST_TAP = CW'(NUM_TAPS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              state, state_d;
  logic [CW-1:0]       tap_d;
  logic [DW-1:0]       drain_cnt, drain_cnt_d;
  logic                ovr_set_c;
  logic                first_c, last_c;
  logic [PIPE_DELAY-1:0] load_pipe, load_pipe_d;
  logic [PIPE_DELAY:0]   dump_pipe, dump_pipe_d;
  logic [PW-1:0]       period_cnt, period_d;
  logic                seen, seen_d;
  logic [LW-1:0]       lock_cnt, lock_d;

  // Next-state, burst sequencing, strobe delay lines and lock tracking
  always_comb begin
    state_d     = state;
    tap_d       = '0;
    drain_cnt_d = drain_cnt;
    ovr_set_c   = 1'b0;
    seen_d      = seen;
    period_d    = period_cnt;
    lock_d      = lock_cnt;
    first_c     = mac_valid && (tap_sel == '0);
    last_c      = mac_valid && (tap_sel == LAST_TAP);

    case (state)
      IDLE: begin
        if (enable && sample_en) state_d = RUN;
      end
      RUN: begin
        if (tap_sel == LAST_TAP) begin
          if (enable && sample_en) begin
            state_d = RUN;
          end else if (enable) begin
            state_d = IDLE;
          end else begin
            state_d     = DRAIN;
            drain_cnt_d = '0;
          end
        end else begin
          tap_d     = tap_sel + CW'(1);
          ovr_set_c = sample_en;
        end
      end
      DRAIN: begin
        if (drain_cnt == DW'(PIPE_DELAY)) state_d = IDLE;
        else drain_cnt_d = drain_cnt + DW'(1);
      end
      default: state_d = IDLE;
    endcase

    load_pipe_d = (load_pipe << 1) | PIPE_DELAY'(first_c);
    dump_pipe_d = (dump_pipe << 1) | DPW'(last_c);

    // First strobe after reset only arms the spacing measurement
    if (sample_en) begin
      period_d = '0;
      seen_d   = 1'b1;
      if (seen) begin
        if (period_cnt == PW'(CYCLES_PER_SAMPLE - 1)) begin
          if (lock_cnt != LW'(LOCK_COUNT)) lock_d = lock_cnt + LW'(1);
        end else begin
          lock_d = '0;
        end
      end
    end else if (period_cnt == PW'(PSAT)) begin
      lock_d = '0;
    end else begin
      period_d = period_cnt + PW'(1);
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      drain_cnt  <= '0;
      tap_sel    <= '0;
      mac_valid  <= 1'b0;
      center_en  <= 1'b0;
      load_pipe  <= '0;
      dump_pipe  <= '0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      period_cnt <= '0;
      seen       <= 1'b0;
      lock_cnt   <= '0;
      locked     <= 1'b0;
    end else begin
      state      <= state_d;
      drain_cnt  <= drain_cnt_d;
      tap_sel    <= tap_d;
      mac_valid  <= (state_d == RUN);
      center_en  <= (state_d == RUN) && (tap_d == LAST_TAP);
      load_pipe  <= load_pipe_d;
      dump_pipe  <= dump_pipe_d;
      busy       <= (state_d != IDLE) || (|load_pipe_d) || (|dump_pipe_d);
      overrun    <= (overrun && !err_clr) || ovr_set_c;
      period_cnt <= period_d;
      seen       <= seen_d;
      lock_cnt   <= lock_d;
      locked     <= (lock_d == LW'(LOCK_COUNT));
    end
  end

  assign acc_load = load_pipe[PIPE_DELAY-1];
  assign acc_dump = dump_pipe[PIPE_DELAY];

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer: a 4-tap and a 1-tap instance driven in parallel,
// compared every cycle with an event-scheduling reference model.
module tb_fir_mac_sequencer;

  localparam int MAXC = 4096;
  localparam int CPS  = 4;
  localparam int LC   = 3;

  int nt[2] = '{4, 1};
  int pd[2] = '{7, 1};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic sample_en = 1'b0;
  logic err_clr = 1'b0;

  logic [1:0] a_tap;
  logic       a_valid, a_center, a_load, a_dump, a_busy, a_ovr, a_locked;
  logic [0:0] b_tap;
  logic       b_valid, b_center, b_load, b_dump, b_busy, b_ovr, b_locked;

  fir_mac_sequencer #(.NUM_TAPS(4), .CW(2), .PIPE_DELAY(7),
                      .CYCLES_PER_SAMPLE(CPS), .LOCK_COUNT(LC)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .sample_en(sample_en),
    .err_clr(err_clr), .tap_sel(a_tap), .mac_valid(a_valid),
    .center_en(a_center), .acc_load(a_load), .acc_dump(a_dump),
    .busy(a_busy), .overrun(a_ovr), .locked(a_locked)
  );

  fir_mac_sequencer #(.NUM_TAPS(1), .CW(1), .PIPE_DELAY(1),
                      .CYCLES_PER_SAMPLE(CPS), .LOCK_COUNT(LC)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .sample_en(sample_en),
    .err_clr(err_clr), .tap_sel(b_tap), .mac_valid(b_valid),
    .center_en(b_center), .acc_load(b_load), .acc_dump(b_dump),
    .busy(b_busy), .overrun(b_ovr), .locked(b_locked)
  );

  always #5 clk = ~clk;

  // Model: burst position (-1 = none), drain cycles left, and absolute-cycle
  // schedules of the accumulator strobes.
  int m_pos[2], m_drain[2], m_period[2], m_good[2];
  bit m_seen[2], m_ovr[2], m_locked[2];
  bit sch_load[2][MAXC];
  bit sch_dump[2][MAXC];
  int cyc = 0;
  int checks = 0;
  int passed = 0;
  int fails = 0;

  // Vector layout: valid, tap[1:0], center, load, dump, busy, overrun, locked
  function automatic logic [8:0] expected(int i);
    bit valid, busy;
    int t;
    valid = (m_pos[i] >= 0);
    t     = valid ? m_pos[i] : 0;
    busy  = valid || (m_drain[i] > 0);
    for (int k = 0; k <= pd[i]; k++) begin
      if (sch_dump[i][cyc + k]) busy = 1'b1;
      if (k < pd[i] && sch_load[i][cyc + k]) busy = 1'b1;
    end
    return {valid, 2'(t), valid && (t == nt[i] - 1), sch_load[i][cyc],
            sch_dump[i][cyc], busy, m_ovr[i], m_locked[i]};
  endfunction

  function automatic logic [8:0] obs_a();
    return {a_valid, a_tap & {2{a_valid}}, a_center, a_load, a_dump,
            a_busy, a_ovr, a_locked};
  endfunction

  function automatic logic [8:0] obs_b();
    return {b_valid, 1'b0, b_tap[0] & b_valid, b_center, b_load, b_dump,
            b_busy, b_ovr, b_locked};
  endfunction

  task automatic check_one(input string tag, input logic [8:0] obs,
                           input logic [8:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s cycle %0d: observed %b required %b", tag, cyc, obs, exp);
    end
  endtask

  // Advance the model by one clock given the inputs sampled at that edge
  task automatic model_step(input bit en, input bit se, input bit clr,
                            input bit rst);
    int np, nd;
    bit set;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_pos[i] = -1; m_drain[i] = 0; m_ovr[i] = 1'b0; m_period[i] = 0;
        m_good[i] = 0; m_seen[i] = 1'b0; m_locked[i] = 1'b0;
        for (int k = cyc + 1; k < MAXC; k++) begin
          sch_load[i][k] = 1'b0;
          sch_dump[i][k] = 1'b0;
        end
      end else begin
        np = -1; nd = 0; set = 1'b0;
        if (m_pos[i] >= 0) begin
          if (m_pos[i] == 0) sch_load[i][cyc + pd[i]] = 1'b1;
          if (m_pos[i] == nt[i] - 1) begin
            sch_dump[i][cyc + pd[i] + 1] = 1'b1;
            if (en && se) np = 0;
            else if (!en) nd = pd[i] + 1;
          end else begin
            np  = m_pos[i] + 1;
            set = se;
          end
        end else if (m_drain[i] > 0) begin
          nd = m_drain[i] - 1;
        end else if (en && se) begin
          np = 0;
        end
        m_pos[i]   = np;
        m_drain[i] = nd;
        m_ovr[i]   = (m_ovr[i] && !clr) || set;
        if (se) begin
          if (m_seen[i])
            m_good[i] = (m_period[i] == CPS - 1) ?
                        ((m_good[i] < LC) ? m_good[i] + 1 : LC) : 0;
          m_seen[i]   = 1'b1;
          m_period[i] = 0;
        end else if (m_period[i] == 2 * CPS) begin
          m_good[i] = 0;
        end else begin
          m_period[i]++;
        end
        m_locked[i] = (m_good[i] == LC);
      end
    end
  endtask

  task automatic step(input bit en, input bit se, input bit clr, input bit rst);
    @(negedge clk);
    check_one("dut_a", obs_a(), expected(0));
    check_one("dut_b", obs_b(), expected(1));
    enable    = en;
    sample_en = se;
    err_clr   = clr;
    reset     = rst;
    model_step(en, se, clr, rst);
    cyc++;
  endtask

  int gap;
  bit ren, rse, rclr, rrst;

  initial begin
    model_step(1'b0, 1'b0, 1'b0, 1'b1);

    // Reset state
    repeat (3) step(0, 0, 0, 1);
    repeat (2) step(1, 0, 0, 0);

    // Back-to-back bursts at the nominal period, lock acquisition
    repeat (8) begin
      step(1, 1, 0, 0);
      repeat (3) step(1, 0, 0, 0);
    end
    // One long interval breaks lock, then relock
    step(1, 1, 0, 0);
    repeat (4) step(1, 0, 0, 0);
    repeat (5) begin
      step(1, 1, 0, 0);
      repeat (3) step(1, 0, 0, 0);
    end
    repeat (12) step(1, 0, 0, 0);

    // Overrun mid-burst, then clear
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    repeat (6) step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    repeat (4) step(1, 0, 0, 0);

    // Overrun set and clear in the same cycle: set wins
    step(1, 1, 0, 0);
    step(1, 1, 1, 0);
    repeat (12) step(1, 0, 0, 0);
    step(1, 0, 1, 0);

    // Enable dropped mid-burst: burst completes, drain, strobes ignored
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    repeat (10) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    repeat (5) step(0, 0, 0, 0);

    // Reset mid-burst
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    repeat (12) step(1, 0, 0, 0);

    // Randomized strobes, enable, clears and occasional resets
    gap = 0;
    ren = 1'b1;
    repeat (500) begin
      if (ren) ren = ($urandom_range(0, 39) != 0);
      else     ren = ($urandom_range(0, 7) == 0);
      rse = 1'b0;
      if (gap == 0) begin
        rse = 1'b1;
        gap = ($urandom_range(0, 9) < 7) ? CPS - 1 : int'($urandom_range(0, 6));
      end else begin
        gap--;
      end
      rclr = ($urandom_range(0, 15) == 0);
      rrst = ($urandom_range(0, 199) == 0);
      step(ren, rse, rclr, rrst);
    end
    repeat (20) step(0, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
